// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO of {pc, instr}, flush overrides push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count  = count_q;
  assign head_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: fetch PC, 4x byte-lane sync-read memory, prefetch queue.
// FETCH_BOOTLOADER_EN enables the bl_* write path and address mux; otherwise the
// memory is read-only and its contents are preloaded by the environment.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  output logic [$clog2(DEPTH):0]  ifq_count,
  input  logic                    bl_stall,
  input  logic [3:0]              bl_wr_strobe,
  input  logic [ADDR_W-1:0]       bl_wraddr,
  input  logic [31:0]             bl_wrdata
);

  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W     = CNT_W + 1;
  localparam int unsigned MEM_WORDS = 2 ** ADDR_W;

  logic [31:0]        fpc_q, fpc_d;
  logic               inflight_q, inflight_d;
  logic [31:0]        rd_pc_q, rd_pc_d;
  logic [3:0][7:0]    mem [MEM_WORDS];
  logic [3:0][7:0]    mem_rdata;
  logic               stall_c;
  logic [3:0]         mem_we_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic               issue_c;
  logic               push_c;
  logic               pop_c;
  fetch_entry_t       head_c;
  logic               unused_redir_lsb;

`ifdef FETCH_BOOTLOADER_EN
  assign stall_c  = bl_stall;
  assign mem_we_c = bl_stall ? bl_wr_strobe : 4'b0000;
`else
  logic unused_bl;
  assign stall_c   = 1'b0;
  assign mem_we_c  = 4'b0000;
  assign unused_bl = ^{bl_stall, bl_wr_strobe};
`endif

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign mem_addr_c = stall_c ? bl_wraddr : fpc_q[ADDR_W+1:2];

  // Credit check uses registered occupancy only, keeping out_ready off the address path.
  assign issue_c = !rst && !redirect_valid && !stall_c &&
                   ((SUM_W'(ifq_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));

  // A returning read is dropped when a redirect or reset lands on its push edge.
  assign push_c = inflight_q && !redirect_valid && !rst;
  assign pop_c  = out_valid && out_ready;

  // Fetch PC and inflight tracking.
  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = issue_c;
    rd_pc_d    = rd_pc_q;
    if (rst) begin
      fpc_d = RESET_PC;
    end else if (redirect_valid) begin
      fpc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue_c) begin
      fpc_d   = fpc_q + 32'd4;
      rd_pc_d = fpc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      rd_pc_q    <= 32'd0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      rd_pc_q    <= rd_pc_d;
    end
  end

  // Four byte-lane banks sharing one address; read data registered on issue.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_c[b]) begin
        mem[mem_addr_c][b] <= bl_wrdata[8*b +: 8];
      end
    end
    if (issue_c) begin
      mem_rdata <= mem[mem_addr_c];
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_c),
    .push_data (fetch_entry_t'{pc: rd_pc_q, instr: mem_rdata}),
    .pop       (pop_c),
    .count     (ifq_count),
    .head_c    (head_c)
  );

  assign out_valid = (ifq_count != '0);
  assign out_instr = out_valid ? head_c.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head_c.pc    : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected PC stream pushed by the driver,
// compared by a negedge monitor against a memory model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam int unsigned MEM_WORDS = 2 ** ADDR_W;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [CNT_W-1:0]  ifq_count;
  logic              bl_stall = 1'b0;
  logic [3:0]        bl_wr_strobe = 4'h0;
  logic [ADDR_W-1:0] bl_wraddr = '0;
  logic [31:0]       bl_wrdata = 32'd0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_model [MEM_WORDS];
  logic [31:0] exp_q [$];
  logic [31:0] exp_next = RESET_PC;

  fetch_queue #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .ifq_count      (ifq_count),
    .bl_stall       (bl_stall),
    .bl_wr_strobe   (bl_wr_strobe),
    .bl_wraddr      (bl_wraddr),
    .bl_wrdata      (bl_wrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_instr(input logic [31:0] pc);
    return mem_model[pc[ADDR_W+1:2]];
  endfunction

  // Each driven cycle adds one more expected PC; the DUT delivers at most one per cycle.
  task automatic tick();
    @(posedge clk);
    exp_q.push_back(exp_next);
    exp_next += 32'd4;
    #1;
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = {pc[31:2], 2'b00};
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    restart(target);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    restart(RESET_PC);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: output-side invariants and in-order stream comparison.
  always @(negedge clk) begin
    check("count_bound", 32'(ifq_count <= CNT_W'(DEPTH)), 32'd1);
    if (!out_valid) begin
      check("idle_instr", out_instr, NOP_INSTR);
      check("idle_pc", out_pc, 32'd0);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: got pc %h expected no output at %0t", out_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, model_instr(e));
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] w;
    bit          seen;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      w = (i < 8) ? (32'h100 + 32'(i)) : $urandom;
      mem_model[i] = w;
      dut.mem[i]   = w;
    end

    // Reset state and cold start.
    out_ready = 1'b1;
    do_reset(3);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(ifq_count), 32'd0);
    check("rst_instr", out_instr, NOP_INSTR);
    check("rst_pc", out_pc, 32'd0);
    tick();
    @(negedge clk);
    check("cold_c1_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("cold_c2_valid", 32'(out_valid), 32'd1);
    check("cold_c2_pc", out_pc, 32'd0);
    check("cold_c2_instr", out_instr, 32'h100);
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      check("steady_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure from reset: queue saturates, nothing lost on release.
    tick();
    out_ready = 1'b0;
    do_reset(1);
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("full_count", 32'(ifq_count), DEPTH);
    tick();
    out_ready = 1'b1;
    repeat (8) tick();

    // Redirect while the queue is backed up.
    out_ready = 1'b0;
    repeat (3) tick();
    do_redirect(32'h43);
    out_ready = 1'b1;
    @(negedge clk);
    check("redir_c1_valid", 32'(out_valid), 32'd0);
    check("redir_c1_count", 32'(ifq_count), 32'd0);
    tick();
    @(negedge clk);
    check("redir_c2_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_c3_valid", 32'(out_valid), 32'd1);
    check("redir_c3_pc", out_pc, 32'h40);
    repeat (6) tick();

    // Redirect coinciding with a pop.
    @(negedge clk);
    check("pre_pop_valid", 32'(out_valid), 32'd1);
    tick();
    do_redirect(32'h200);
    @(negedge clk);
    check("redir_pop_count", 32'(ifq_count), 32'd0);
    repeat (6) tick();

    // One-cycle reset pulse mid-stream.
    do_reset(1);
    @(negedge clk);
    check("pulse_valid", 32'(out_valid), 32'd0);
    repeat (6) tick();

`ifdef FETCH_BOOTLOADER_EN
    // Boot write through the stalled memory port, then fetch it.
    do_redirect(32'h800);
    repeat (6) tick();
    bl_stall     = 1'b1;
    bl_wr_strobe = 4'hF;
    bl_wraddr    = ADDR_W'(5);
    bl_wrdata    = 32'hDEAD_BEEF;
    tick();
    mem_model[5] = 32'hDEAD_BEEF;
    bl_wr_strobe = 4'h0;
    repeat (3) tick();
    bl_stall = 1'b0;
    do_redirect(32'h14);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == 32'h14) begin
        seen = 1'b1;
        check("bl_instr", out_instr, 32'hDEAD_BEEF);
      end
      tick();
    end
    check("bl_seen", 32'(seen), 32'd1);
`else
    seen = 1'b0;
`endif

    // Randomised traffic with redirects, wrap-around targets and resets.
    for (int i = 0; i < 1500; i++) begin
      tick();
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 40 == 0) begin
        if ($urandom % 3 == 0) begin
          do_redirect(32'hFFFF_FFF0 + 32'(($urandom % 4) * 4));
        end else begin
          do_redirect($urandom);
        end
      end else if ($urandom % 250 == 0) begin
        do_reset(1);
      end
    end

    out_ready = 1'b1;
    repeat (10) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
